// File: rtl/key_gpi_reader_pkg.sv
// Shared definitions for the key GPI reader: GPI word field layout and helpers.
// The field offsets are the same ones the firmware register map and the bench use.
package key_gpi_reader_pkg;

  localparam int GPI_LVL_LSB  = 0;
  localparam int GPI_PEND_LSB = 8;
  localparam int GPI_CNT_LSB  = 16;
  localparam int GPI_CNT_W    = 8;
  localparam int GPI_FIELD_W  = 8;
  localparam int GPI_MAX_KEYS = 8;

  // Packed view of the 32-bit status word, MSB field first.
  typedef struct packed {
    logic [7:0] rsvd;
    logic [7:0] press_cnt;
    logic [7:0] pending;
    logic [7:0] level;
  } gpi_t;

  function automatic logic [7:0] popcount8(input logic [7:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, stability counter and accepted level; flags a press
// on the cycle a new pressed level is accepted (2 + DB_CYCLES edges after the pin edge).
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_press_evt
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_accept;

  assign w_differs = (r_sync2 != r_stable);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any return to the accepted level throws away the partial count.
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable    = r_stable;
  assign o_press_evt = w_accept & r_sync2;

endmodule

// File: rtl/key_gpi_reader.sv
// Push-button reader for the CPU GPI port: debounced levels, sticky press flags
// cleared by an ack rising edge, an 8-bit press counter and a level irq.
module key_gpi_reader
  import key_gpi_reader_pkg::*;
#(
  parameter int NUM_KEYS   = 2,
  parameter int DB_CYCLES  = 1_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                ack,
  input  logic [NUM_KEYS-1:0] ack_mask,
  output logic [31:0]         gpi,
  output logic                irq
);

  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:0] w_press_evt;
  logic [NUM_KEYS-1:0] w_clr;
  logic                w_ack_rise;
  logic [7:0]          w_evt8;
  logic [7:0]          w_lvl8;
  logic [7:0]          w_pend8;
  gpi_t                w_gpi;

  logic                r_ack_q;
  logic [NUM_KEYS-1:0] r_pending;
  logic [7:0]          r_press_cnt;

  assign w_raw = ACTIVE_LOW ? ~keys : keys;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk         (clk),
      .reset       (reset),
      .i_raw       (w_raw[gi]),
      .o_stable    (w_stable[gi]),
      .o_press_evt (w_press_evt[gi])
    );
  end

  assign w_ack_rise = ack & ~r_ack_q;
  assign w_clr      = w_ack_rise ? ack_mask : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack_q     <= 1'b0;
      r_pending   <= '0;
      r_press_cnt <= '0;
    end else begin
      r_ack_q <= ack;
      // A press landing on the same edge as its clear must survive.
      r_pending   <= (r_pending & ~w_clr) | w_press_evt;
      r_press_cnt <= r_press_cnt + popcount8(w_evt8);
    end
  end

  always_comb begin
    w_evt8  = '0;
    w_lvl8  = '0;
    w_pend8 = '0;
    w_evt8[NUM_KEYS-1:0]  = w_press_evt;
    w_lvl8[NUM_KEYS-1:0]  = w_stable;
    w_pend8[NUM_KEYS-1:0] = r_pending;
  end

  always_comb begin
    w_gpi           = '0;
    w_gpi.rsvd      = 8'h00;
    w_gpi.press_cnt = r_press_cnt;
    w_gpi.pending   = w_pend8;
    w_gpi.level     = w_lvl8;
  end

  assign gpi = w_gpi;
  assign irq = |r_pending;

endmodule

// File: tb/tb_key_gpi_reader.sv
// Bench for key_gpi_reader: directed scenarios plus random key/ack traffic, checked every
// cycle against an edge-history model of the debounce/pending/counter rules.
module tb_key_gpi_reader;
  import key_gpi_reader_pkg::*;

  localparam int NK   = 2;
  localparam int DB   = 16;
  localparam int MAXE = 16384;

  logic          clk;
  logic          reset;
  logic [NK-1:0] keys;
  logic          ack;
  logic [NK-1:0] ack_mask;
  logic [31:0]   gpi;
  logic          irq;

  int total = 0;
  int bad   = 0;

  key_gpi_reader #(
    .NUM_KEYS   (NK),
    .DB_CYCLES  (DB),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .keys     (keys),
    .ack      (ack),
    .ack_mask (ack_mask),
    .gpi      (gpi),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per key, the pressed value of the pin at every edge since reset; the
  // synchronised value seen at edge e is the pin value two edges earlier, and a level
  // is accepted when the last DB synchronised values all disagree with it.
  bit rawv  [NK][MAXE];
  bit syncv [NK][MAXE];
  bit m_stable [NK];
  bit m_pend   [NK];
  int m_cnt;
  int m_edge;
  bit m_ack_prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edge     = 0;
      m_cnt      = 0;
      m_ack_prev = 1'b0;
      for (int i = 0; i < NK; i++) begin
        m_stable[i] = 1'b0;
        m_pend[i]   = 1'b0;
      end
    end else begin
      bit press [NK];
      bit ack_rise;
      int evts;
      m_edge = m_edge + 1;
      if (m_edge >= MAXE) begin
        $display("FAIL model_edge_budget edges=%0d limit=%0d", m_edge, MAXE);
        $fatal(1, "model history exhausted");
      end
      evts = 0;
      for (int i = 0; i < NK; i++) begin
        bit all_diff;
        press[i] = 1'b0;
        rawv[i][m_edge]  = ~keys[i];
        syncv[i][m_edge] = (m_edge >= 3) ? rawv[i][m_edge-2] : 1'b0;
        all_diff = (m_edge >= DB);
        for (int j = m_edge - DB + 1; j <= m_edge; j++) begin
          if (j < 1 || syncv[i][j] == m_stable[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_stable[i] = ~m_stable[i];
          if (m_stable[i]) begin
            press[i] = 1'b1;
            evts = evts + 1;
          end
        end
      end
      ack_rise   = ack && !m_ack_prev;
      m_ack_prev = ack;
      for (int i = 0; i < NK; i++) begin
        if (press[i]) m_pend[i] = 1'b1;
        else if (ack_rise && ack_mask[i]) m_pend[i] = 1'b0;
      end
      m_cnt = (m_cnt + evts) % 256;
    end
  end

  function automatic logic [31:0] model_gpi();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < NK; i++) begin
      w[GPI_LVL_LSB + i]  = m_stable[i];
      w[GPI_PEND_LSB + i] = m_pend[i];
    end
    w[GPI_CNT_LSB +: GPI_CNT_W] = m_cnt[7:0];
    return w;
  endfunction

  function automatic logic model_irq();
    logic any;
    any = 1'b0;
    for (int i = 0; i < NK; i++) any = any | m_pend[i];
    return any;
  endfunction

  always @(negedge clk) begin
    logic [31:0] eg;
    logic        ei;
    eg = model_gpi();
    ei = model_irq();
    total = total + 1;
    if (gpi !== eg) begin
      bad = bad + 1;
      $display("FAIL model_gpi t=%0t got=%h want=%h", $time, gpi, eg);
    end
    total = total + 1;
    if (irq !== ei) begin
      bad = bad + 1;
      $display("FAIL model_irq t=%0t got=%b want=%b", $time, irq, ei);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_gpi", gpi, 32'h0);
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    keys     = 2'b11;
    ack      = 1'b0;
    ack_mask = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset and idle with keys released
    do_reset();
    repeat (40) @(negedge clk);
    check("idle_gpi", gpi, 32'h0);

    // 2: clean press on key0, accepted on the 18th edge
    @(negedge clk);
    keys[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1 check("press_edge17_lvl", {31'd0, gpi[0]}, 32'd0);
    @(posedge clk);
    #1;
    check("press_edge18_lvl",  {31'd0, gpi[0]}, 32'd1);
    check("press_edge18_pend", {31'd0, gpi[8]}, 32'd1);
    check("press_edge18_cnt",  {24'd0, gpi[23:16]}, 32'd1);
    check("press_edge18_irq",  {31'd0, irq}, 32'd1);

    // 3: bouncing key0 gives exactly one event after the final edge
    @(negedge clk);
    keys = 2'b11;
    do_reset();
    repeat (5) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      keys[0] = ~keys[0];
      repeat (5) @(negedge clk);
    end
    keys[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1 check("bounce_edge17_lvl", {31'd0, gpi[0]}, 32'd0);
    check("bounce_edge17_cnt", {24'd0, gpi[23:16]}, 32'd0);
    @(posedge clk);
    #1;
    check("bounce_edge18_word", gpi, 32'h0001_0101);

    // 4: ack clears key0; a new press while ack stays high re-sets pending
    @(negedge clk);
    ack_mask = 2'b01;
    ack      = 1'b1;
    @(posedge clk);
    #1;
    check("ack_clr_pend", {31'd0, gpi[8]}, 32'd0);
    check("ack_clr_irq",  {31'd0, irq}, 32'd0);
    @(negedge clk);
    keys[0] = 1'b1;
    repeat (30) @(negedge clk);
    keys[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("ack_held_repress_pend", {31'd0, gpi[8]}, 32'd1);
    check("ack_held_repress_irq",  {31'd0, irq}, 32'd1);
    check("ack_held_cnt", {24'd0, gpi[23:16]}, 32'd2);
    ack = 1'b0;

    // 5: press event on key1 coincides with an ack rising edge selecting key1
    keys = 2'b11;
    do_reset();
    repeat (5) @(negedge clk);
    keys[1] = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    ack_mask = 2'b10;
    ack      = 1'b1;
    @(posedge clk);
    #1;
    check("collide_pend1", {31'd0, gpi[9]}, 32'd1);
    check("collide_irq",   {31'd0, irq}, 32'd1);
    @(negedge clk);
    ack = 1'b0;

    // 6: counter wraps after 256 presses; simultaneous presses add two
    keys = 2'b11;
    do_reset();
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      if (n == 255) check("wrap_cnt_255", {24'd0, gpi[23:16]}, 32'd255);
      keys[1] = 1'b0;
      repeat (20) @(negedge clk);
      keys[1] = 1'b1;
      repeat (20) @(negedge clk);
    end
    check("wrap_cnt_0", {24'd0, gpi[23:16]}, 32'd0);
    @(negedge clk);
    keys = 2'b00;
    repeat (18) @(posedge clk);
    #1;
    check("both_cnt",  {24'd0, gpi[23:16]}, 32'd2);
    check("both_pend", {30'd0, gpi[9:8]}, 32'd3);
    check("both_lvl",  {30'd0, gpi[1:0]}, 32'd3);

    // random traffic with a mid-run asynchronous reset
    @(negedge clk);
    keys = 2'b11;
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      int p;
      p = $urandom_range(2, 15);
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 99) < p) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
        if ($urandom_range(0, 99) < 10) ack = ~ack;
        if ($urandom_range(0, 99) < 20) ack_mask = NK'($urandom);
        if (seg == 4 && c == 250) begin
          #2 reset = 1'b1;
          #4 reset = 1'b0;
        end
      end
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
